// File: rtl/maccumulator_nch_pkg.sv
// Shared definitions for the multi-channel money accumulator.
// Refund FSM state encoding, default denomination table and credit-width helper.
package maccumulator_nch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PAY  = 2'd1,
        S_GAP  = 2'd2
    } macc_state_e;

    localparam logic [23:0] MACC_DENOM_DEFAULT = {8'd50, 8'd10, 8'd1};

    // Credit sum width: large enough that all channels firing together never truncates.
    function automatic int unsigned macc_cw(input int unsigned width, input int unsigned nch);
        return width + $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/maccumulator_nch_if.sv
// Coin/deduct/refund signal bundle between the vend controller (master) and the accumulator (slave).
interface maccumulator_nch_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 3
);
    logic             lock;
    logic             clr;
    logic [NCH-1:0]   coin_sig;
    logic             deduct_req;
    logic [WIDTH-1:0] deduct_amt;
    logic             deduct_ack;
    logic             deduct_nak;
    logic [NCH-1:0]   coin_reject;
    logic [WIDTH-1:0] moneyv;
    logic             refund_req;
    logic [NCH-1:0]   change_out;
    logic             refund_done;

    modport master (
        output lock, clr, coin_sig, deduct_req, deduct_amt, refund_req,
        input  deduct_ack, deduct_nak, coin_reject, moneyv, change_out, refund_done
    );

    modport slave (
        input  lock, clr, coin_sig, deduct_req, deduct_amt, refund_req,
        output deduct_ack, deduct_nak, coin_reject, moneyv, change_out, refund_done
    );
endinterface

// File: rtl/maccumulator_nch_edge_det.sv
// Rising-edge detector for the raw coin switches; history updates every cycle regardless of lock/refund.
module macc_edge_det #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sig_i,
    output logic [N-1:0] rise_o
);
    logic [N-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= sig_i;
    end

    assign rise_o = sig_i & ~prev_q;
endmodule

// File: rtl/maccumulator_nch.sv
// Saturating multi-denomination money accumulator with deduct ack/nak.
// Greedy change refund FSM is built only when MACC_REFUND_EN is defined.
module maccumulator_nch
    import maccumulator_nch_pkg::*;
#(
    parameter int unsigned          WIDTH  = 8,
    parameter int unsigned          NCH    = 3,
    parameter logic [NCH*WIDTH-1:0] DENOM  = MACC_DENOM_DEFAULT,
    parameter logic [WIDTH-1:0]     MAXVAL = '1
) (
    input logic               cp,
    input logic               rst,
    maccumulator_nch_if.slave bus
);
    localparam int unsigned CW = macc_cw(WIDTH, NCH);

    logic [NCH-1:0]   rise;
    logic [CW-1:0]    credit;
    logic [CW-1:0]    net;
    logic [WIDTH-1:0] debit;
    logic             debit_ok;
    logic             accept;
    logic             idle;

    logic [WIDTH-1:0] moneyv_q, moneyv_d;
    logic             ack_q, ack_d;
    logic             nak_q, nak_d;
    logic [NCH-1:0]   reject_q, reject_d;
    logic [NCH-1:0]   change_q, change_d;
    logic             done_q, done_d;

    macc_edge_det #(.N(NCH)) u_edge (
        .clk    (cp),
        .rst_n  (rst),
        .sig_i  (bus.coin_sig),
        .rise_o (rise)
    );

    always_comb begin
        credit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (rise[i]) credit = credit + CW'(DENOM[i*WIDTH +: WIDTH]);
        end
    end

    // debit never exceeds the pre-credit balance, so net cannot underflow.
    assign debit_ok = bus.deduct_req && idle && !bus.clr && (bus.deduct_amt <= moneyv_q);
    assign debit    = debit_ok ? bus.deduct_amt : '0;
    assign net      = CW'(moneyv_q) + credit - CW'(debit);
    assign accept   = !bus.lock && idle && !bus.clr && (net <= CW'(MAXVAL));

`ifdef MACC_REFUND_EN
    macc_state_e      state_q, state_d;
    logic             pay_found;
    logic [WIDTH-1:0] pay_val;
    logic [NCH-1:0]   pay_sel;

    assign idle = (state_q == S_IDLE);

    always_comb begin
        pay_found = 1'b0;
        pay_val   = '0;
        pay_sel   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (DENOM[i*WIDTH +: WIDTH] <= moneyv_q && DENOM[i*WIDTH +: WIDTH] > pay_val) begin
                pay_found  = 1'b1;
                pay_val    = DENOM[i*WIDTH +: WIDTH];
                pay_sel    = '0;
                pay_sel[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge cp or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end
`else
    assign idle = 1'b1;
`endif

    always_comb begin
        moneyv_d = moneyv_q;
        ack_d    = 1'b0;
        nak_d    = 1'b0;
        reject_d = '0;
        change_d = '0;
        done_d   = 1'b0;
        if (bus.clr) begin
            moneyv_d = '0;
            nak_d    = bus.deduct_req;
            reject_d = rise;
        end else begin
            ack_d = debit_ok;
            nak_d = bus.deduct_req && !debit_ok;
            if (accept) begin
                moneyv_d = WIDTH'(net);
            end else begin
                moneyv_d = moneyv_q - debit;
                reject_d = rise;
            end
        end
`ifdef MACC_REFUND_EN
        state_d = state_q;
        if (bus.clr) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.refund_req) begin
                        if (moneyv_q != '0) state_d = S_PAY;
                        else                done_d  = 1'b1;
                    end
                end
                S_PAY: begin
                    if (pay_found) begin
                        change_d = pay_sel;
                        moneyv_d = moneyv_q - pay_val;
                        state_d  = S_GAP;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (pay_found) begin
                        state_d = S_PAY;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
`endif
    end

    always_ff @(posedge cp or negedge rst) begin
        if (!rst) begin
            moneyv_q <= '0;
            ack_q    <= 1'b0;
            nak_q    <= 1'b0;
            reject_q <= '0;
            change_q <= '0;
            done_q   <= 1'b0;
        end else begin
            moneyv_q <= moneyv_d;
            ack_q    <= ack_d;
            nak_q    <= nak_d;
            reject_q <= reject_d;
            change_q <= change_d;
            done_q   <= done_d;
        end
    end

    assign bus.moneyv      = moneyv_q;
    assign bus.deduct_ack  = ack_q;
    assign bus.deduct_nak  = nak_q;
    assign bus.coin_reject = reject_q;
    assign bus.change_out  = change_q;
    assign bus.refund_done = done_q;
endmodule

// File: tb/tb_maccumulator_nch.sv
// Scoreboard bench for maccumulator_nch: directed vectors push expectations, a monitor pops and compares.
module tb_maccumulator_nch;
    logic cp;
    logic rst;

    maccumulator_nch_if #(.WIDTH(8), .NCH(3)) bus ();

    maccumulator_nch #(.WIDTH(8), .NCH(3)) dut (
        .cp  (cp),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        string      nm;
        logic [7:0] m;
        logic       ack;
        logic       nak;
        logic [2:0] rej;
        logic [2:0] chg;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial cp = 1'b0;
    always #5 cp = ~cp;

    task automatic chk(input string nm, input string fld, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d", nm, fld, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge cp);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.nm, "moneyv", bus.moneyv, e.m);
                chk(e.nm, "ack", bus.deduct_ack, e.ack);
                chk(e.nm, "nak", bus.deduct_nak, e.nak);
                chk(e.nm, "reject", bus.coin_reject, e.rej);
                chk(e.nm, "change", bus.change_out, e.chg);
                chk(e.nm, "done", bus.refund_done, e.done);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge.
    task automatic step(input string nm, input logic r, input logic lk, input logic cl,
                        input logic [2:0] coin, input logic req, input logic [7:0] amt, input logic rf,
                        input logic [7:0] m, input logic ack, input logic nak,
                        input logic [2:0] rej, input logic [2:0] chg, input logic done);
        exp_t e;
        @(negedge cp);
        rst            = r;
        bus.lock       = lk;
        bus.clr        = cl;
        bus.coin_sig   = coin;
        bus.deduct_req = req;
        bus.deduct_amt = amt;
        bus.refund_req = rf;
        e.nm = nm; e.m = m; e.ack = ack; e.nak = nak; e.rej = rej; e.chg = chg; e.done = done;
        sb.push_back(e);
    endtask

    initial begin : stim
        int wait_cyc;
        rst = 1'b0;
        bus.lock = 1'b0; bus.clr = 1'b0; bus.coin_sig = '0;
        bus.deduct_req = 1'b0; bus.deduct_amt = '0; bus.refund_req = 1'b0;

        step("reset0", 0,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("reset1", 0,0,0, 3'b001,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        // coin_sig[0] already high as reset releases: history is 0, so it counts as an edge
        step("c1",     1,0,0, 3'b001,0,8'd0,0,   8'd1,  0,0,3'b000,3'b000,0);
        step("c1hold", 1,0,0, 3'b001,0,8'd0,0,   8'd1,  0,0,3'b000,3'b000,0);
        step("c1low",  1,0,0, 3'b000,0,8'd0,0,   8'd1,  0,0,3'b000,3'b000,0);
        step("c10",    1,0,0, 3'b010,0,8'd0,0,   8'd11, 0,0,3'b000,3'b000,0);
        step("idle0",  1,0,0, 3'b000,0,8'd0,0,   8'd11, 0,0,3'b000,3'b000,0);
        step("c60",    1,0,0, 3'b110,0,8'd0,0,   8'd71, 0,0,3'b000,3'b000,0);
        step("idle1",  1,0,0, 3'b000,0,8'd0,0,   8'd71, 0,0,3'b000,3'b000,0);
        step("lockrej",1,1,0, 3'b100,0,8'd0,0,   8'd71, 0,0,3'b100,3'b000,0);
        step("lockded",1,1,0, 3'b000,1,8'd20,0,  8'd51, 1,0,3'b000,3'b000,0);
        step("nak60",  1,0,0, 3'b000,1,8'd60,0,  8'd51, 0,1,3'b000,3'b000,0);
        step("a50a",   1,0,0, 3'b100,0,8'd0,0,   8'd101,0,0,3'b000,3'b000,0);
        step("z0",     1,0,0, 3'b000,0,8'd0,0,   8'd101,0,0,3'b000,3'b000,0);
        step("a50b",   1,0,0, 3'b100,0,8'd0,0,   8'd151,0,0,3'b000,3'b000,0);
        step("z1",     1,0,0, 3'b000,0,8'd0,0,   8'd151,0,0,3'b000,3'b000,0);
        step("a50c",   1,0,0, 3'b100,0,8'd0,0,   8'd201,0,0,3'b000,3'b000,0);
        step("z2",     1,0,0, 3'b000,0,8'd0,0,   8'd201,0,0,3'b000,3'b000,0);
        step("a50d",   1,0,0, 3'b100,0,8'd0,0,   8'd251,0,0,3'b000,3'b000,0);
        step("d1",     1,0,0, 3'b000,1,8'd1,0,   8'd250,1,0,3'b000,3'b000,0);
        step("ceilok", 1,0,0, 3'b010,1,8'd5,0,   8'd255,1,0,3'b000,3'b000,0);
        step("d5",     1,0,0, 3'b000,1,8'd5,0,   8'd250,1,0,3'b000,3'b000,0);
        step("ceilrej",1,0,0, 3'b010,0,8'd0,0,   8'd250,0,0,3'b010,3'b000,0);
        step("z3",     1,0,0, 3'b000,0,8'd0,0,   8'd250,0,0,3'b000,3'b000,0);
        step("ceil256",1,0,0, 3'b010,1,8'd4,0,   8'd246,1,0,3'b010,3'b000,0);
        step("z4",     1,0,0, 3'b000,0,8'd0,0,   8'd246,0,0,3'b000,3'b000,0);
        step("amt0",   1,0,0, 3'b000,1,8'd0,0,   8'd246,1,0,3'b000,3'b000,0);
        step("dall",   1,0,0, 3'b000,1,8'd246,0, 8'd0,  1,0,3'b000,3'b000,0);
        step("dempty", 1,0,0, 3'b000,1,8'd1,0,   8'd0,  0,1,3'b000,3'b000,0);
        step("c61",    1,0,0, 3'b111,0,8'd0,0,   8'd61, 0,0,3'b000,3'b000,0);
        step("z5",     1,0,0, 3'b000,0,8'd0,0,   8'd61, 0,0,3'b000,3'b000,0);
        step("c62",    1,0,0, 3'b001,0,8'd0,0,   8'd62, 0,0,3'b000,3'b000,0);
        step("z6",     1,0,0, 3'b000,0,8'd0,0,   8'd62, 0,0,3'b000,3'b000,0);
`ifdef MACC_REFUND_EN
        step("rf_go",  1,0,0, 3'b000,0,8'd0,1,   8'd62, 0,0,3'b000,3'b000,0);
        step("rf_p50", 1,0,0, 3'b000,0,8'd0,0,   8'd12, 0,0,3'b000,3'b100,0);
        step("rf_coin",1,0,0, 3'b001,0,8'd0,0,   8'd12, 0,0,3'b001,3'b000,0);
        step("rf_p10", 1,0,0, 3'b000,0,8'd0,0,   8'd2,  0,0,3'b000,3'b010,0);
        step("rf_nak", 1,0,0, 3'b000,1,8'd1,0,   8'd2,  0,1,3'b000,3'b000,0);
        step("rf_p1a", 1,0,0, 3'b000,0,8'd0,0,   8'd1,  0,0,3'b000,3'b001,0);
        step("rf_gap", 1,0,0, 3'b000,0,8'd0,0,   8'd1,  0,0,3'b000,3'b000,0);
        step("rf_p1b", 1,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b001,0);
        step("rf_done",1,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,1);
        step("rf_idle",1,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("rf_zero",1,0,0, 3'b000,0,8'd0,1,   8'd0,  0,0,3'b000,3'b000,1);
        step("c50",    1,0,0, 3'b100,0,8'd0,0,   8'd50, 0,0,3'b000,3'b000,0);
        step("z7",     1,0,0, 3'b000,0,8'd0,0,   8'd50, 0,0,3'b000,3'b000,0);
        step("rf_go2", 1,0,0, 3'b000,0,8'd0,1,   8'd50, 0,0,3'b000,3'b000,0);
        step("rf_rst", 0,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("rf_post",1,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("rf_post2",1,0,0,3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("c10b",   1,0,0, 3'b010,0,8'd0,0,   8'd10, 0,0,3'b000,3'b000,0);
        step("z8",     1,0,0, 3'b000,0,8'd0,0,   8'd10, 0,0,3'b000,3'b000,0);
`else
        step("rf_ign", 1,0,0, 3'b000,0,8'd0,1,   8'd62, 0,0,3'b000,3'b000,0);
        step("rf_ign2",1,0,0, 3'b000,1,8'd2,0,   8'd60, 1,0,3'b000,3'b000,0);
        step("rf_ign3",1,0,0, 3'b000,0,8'd0,0,   8'd60, 0,0,3'b000,3'b000,0);
`endif
        step("clr",    1,0,1, 3'b001,1,8'd5,0,   8'd0,  0,1,3'b001,3'b000,0);
        step("z9",     1,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("c50b",   1,0,0, 3'b100,0,8'd0,0,   8'd50, 0,0,3'b000,3'b000,0);
        step("midrst", 0,0,0, 3'b010,1,8'd5,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("postrst",1,0,0, 3'b000,0,8'd0,0,   8'd0,  0,0,3'b000,3'b000,0);
        step("c11",    1,0,0, 3'b011,0,8'd0,0,   8'd11, 0,0,3'b000,3'b000,0);
        step("z10",    1,0,0, 3'b000,0,8'd0,0,   8'd11, 0,0,3'b000,3'b000,0);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge cp);
            wait_cyc++;
        end
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
